// File: rtl/digdug_pkg.sv
// digdug_pkg
// Shared constants and types for the Dig Dug sprite attribute path.
//   SPATTR_ENTRIES  : attribute words per frame (64 sprites x ATR0/ATR1)
//   SPATTR_DISABLED : word the renderer sees before any table is valid
//                     (ATR1 bit 17 set = sprite disabled)
//   spattr_state_e  : copy engine state encoding
package digdug_pkg;

  localparam int          SPATTR_ENTRIES  = 128;
  localparam int          SPATTR_AW       = 7;
  localparam logic [23:0] SPATTR_DISABLED = 24'h020000;

  typedef enum logic [1:0] {
    SP_IDLE  = 2'd0,
    SP_RUN   = 2'd1,
    SP_DRAIN = 2'd2,
    SP_FLIP  = 2'd3
  } spattr_state_e;

  // True for every state in which a frame copy is in flight.
  function automatic logic spattr_busy(input spattr_state_e s);
    return s != SP_IDLE;
  endfunction

endpackage

// File: rtl/digdug_spattr_ram.sv
// digdug_spattr_ram
// 256 x 24 simple dual-port RAM holding both attribute banks.
//   rclk_i  : clock for both ports
//   we_i    : write enable
//   waddr_i : write address {bank, entry}
//   wdata_i : write data
//   raddr_i : read address {bank, entry}
//   rdata_o : registered read data, one cycle after raddr_i
module digdug_spattr_ram (
  input  logic        rclk_i,
  input  logic        we_i,
  input  logic [7:0]  waddr_i,
  input  logic [23:0] wdata_i,
  input  logic [7:0]  raddr_i,
  output logic [23:0] rdata_o
);

  logic [23:0] mem_q [256];
  logic [23:0] rdata_q;

  always_ff @(posedge rclk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/digdug_spattr_dma.sv
// digdug_spattr_dma
// Copies one frame of sprite attributes from the CPU-side sprite RAM into a
// double-buffered table during VBLANK, then flips banks so the renderer
// always reads a complete, consistent frame.
//   RCLK, RESET     : rendering clock, synchronous active-high reset
//   VBLANK, COPY_EN : copy starts on a VBLANK rising edge while COPY_EN=1
//   SRC_AD, SRC_RD  : source read address / strobe
//   SRC_DT          : source data, valid SRC_LAT cycles after SRC_RD
//   SPATAD, SPATDT  : renderer read port, one-cycle latency
//   BUSY, SWAP      : copy in progress / one-cycle bank flip pulse
module digdug_spattr_dma
  import digdug_pkg::*;
#(
  parameter int ENTRIES = SPATTR_ENTRIES,
  parameter int SRC_LAT = 1
) (
  input  logic        RCLK,
  input  logic        RESET,
  input  logic        VBLANK,
  input  logic        COPY_EN,
  output logic [6:0]  SRC_AD,
  output logic        SRC_RD,
  input  logic [23:0] SRC_DT,
  input  logic [6:0]  SPATAD,
  output logic [23:0] SPATDT,
  output logic        BUSY,
  output logic        SWAP
);

  localparam logic [6:0] LAST_AD    = 7'(ENTRIES - 1);
  localparam logic [1:0] DRAIN_LAST = 2'(SRC_LAT - 1);

  spattr_state_e state_q, state_d;
  logic [6:0]    addr_q, addr_d;
  logic [1:0]    drain_q, drain_d;
  logic          bank_q, bank_d;
  logic          valid_q, valid_d;
  logic          vblank_q;
  logic          rd_valid_q;
  logic          start;

  // Write-valid / write-address pipeline, SRC_LAT deep, aligning each
  // issued address with the data that comes back for it.
  logic [SRC_LAT-1:0] wv_q;
  logic [6:0]         wa_q [SRC_LAT];

  logic [23:0] ram_rdata;

  assign start = VBLANK && !vblank_q && COPY_EN && (state_q == SP_IDLE);

  always_ff @(posedge RCLK) begin
    if (RESET) begin
      state_q  <= SP_IDLE;
      addr_q   <= '0;
      drain_q  <= '0;
      bank_q   <= 1'b0;
      valid_q  <= 1'b0;
      vblank_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      drain_q  <= drain_d;
      bank_q   <= bank_d;
      valid_q  <= valid_d;
      vblank_q <= VBLANK;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    bank_d  = bank_q;
    valid_d = valid_q;
    SRC_RD  = 1'b0;
    SWAP    = 1'b0;
    BUSY    = spattr_busy(state_q);
    case (state_q)
      SP_IDLE: begin
        addr_d  = '0;
        drain_d = '0;
        if (start) begin
          state_d = SP_RUN;
        end
      end
      SP_RUN: begin
        SRC_RD = 1'b1;
        // Stop at the last entry and park the counter at 0; it never wraps.
        if (addr_q == LAST_AD) begin
          addr_d  = '0;
          state_d = SP_DRAIN;
        end else begin
          addr_d = addr_q + 7'd1;
        end
      end
      SP_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = SP_FLIP;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      SP_FLIP: begin
        SWAP    = 1'b1;
        bank_d  = ~bank_q;
        valid_d = 1'b1;
        state_d = SP_IDLE;
      end
      default: state_d = SP_IDLE;
    endcase
  end

  assign SRC_AD = addr_q;

  always_ff @(posedge RCLK) begin
    if (RESET) begin
      wv_q <= '0;
      for (int i = 0; i < SRC_LAT; i++) begin
        wa_q[i] <= '0;
      end
    end else begin
      wv_q[0] <= SRC_RD;
      wa_q[0] <= SRC_AD;
      for (int i = 1; i < SRC_LAT; i++) begin
        wv_q[i] <= wv_q[i-1];
        wa_q[i] <= wa_q[i-1];
      end
    end
  end

  // The read-side valid flag travels alongside the RAM read register so the
  // word and its gate always come from the same clock edge; this keeps a
  // stale bank from leaking out on the first cycle after the initial flip.
  always_ff @(posedge RCLK) begin
    if (RESET) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= valid_q;
    end
  end

  // Writes always go to the bank the renderer is not reading.
  digdug_spattr_ram u_ram (
    .rclk_i  (RCLK),
    .we_i    (wv_q[SRC_LAT-1]),
    .waddr_i ({~bank_q, wa_q[SRC_LAT-1]}),
    .wdata_i (SRC_DT),
    .raddr_i ({bank_q, SPATAD}),
    .rdata_o (ram_rdata)
  );

  assign SPATDT = rd_valid_q ? ram_rdata : SPATTR_DISABLED;

endmodule

// File: tb/tb_digdug_spattr_dma.sv
// tb_digdug_spattr_dma
// Drives two instances (SRC_LAT=1 and SRC_LAT=2) from the same VBLANK,
// COPY_EN and SPATAD stimulus, each with its own source RAM latency
// emulator, and compares every output against a frame-level model.
module tb_digdug_spattr_dma;

  localparam logic [23:0] DISABLED = 24'h020000;
  localparam int          NENT     = 128;

  logic        RCLK = 1'b0;
  logic        RESET;
  logic        VBLANK;
  logic        COPY_EN;
  logic [6:0]  SPATAD;

  logic [6:0]  srcAd  [2];
  logic        srcRd  [2];
  logic [23:0] srcDt  [2];
  logic [23:0] spatDt [2];
  logic        busyO  [2];
  logic        swapO  [2];

  int vectors   = 0;
  int miscomp   = 0;
  bit checking  = 1'b0;

  always #5 RCLK = ~RCLK;

  digdug_spattr_dma #(.ENTRIES(128), .SRC_LAT(1)) u_dut1 (
    .RCLK(RCLK), .RESET(RESET), .VBLANK(VBLANK), .COPY_EN(COPY_EN),
    .SRC_AD(srcAd[0]), .SRC_RD(srcRd[0]), .SRC_DT(srcDt[0]),
    .SPATAD(SPATAD), .SPATDT(spatDt[0]), .BUSY(busyO[0]), .SWAP(swapO[0])
  );

  digdug_spattr_dma #(.ENTRIES(128), .SRC_LAT(2)) u_dut2 (
    .RCLK(RCLK), .RESET(RESET), .VBLANK(VBLANK), .COPY_EN(COPY_EN),
    .SRC_AD(srcAd[1]), .SRC_RD(srcRd[1]), .SRC_DT(srcDt[1]),
    .SPATAD(SPATAD), .SPATDT(spatDt[1]), .BUSY(busyO[1]), .SWAP(swapO[1])
  );

  // Source sprite RAM with a 1-cycle and a 2-cycle read port.
  logic [23:0] srcMem [NENT];
  logic [23:0] pipe1, pipe2a, pipe2b;

  always @(posedge RCLK) begin
    pipe1  <= srcRd[0] ? srcMem[srcAd[0]] : 24'h0;
    pipe2a <= srcRd[1] ? srcMem[srcAd[1]] : 24'h0;
    pipe2b <= pipe2a;
  end

  assign srcDt[0] = pipe1;
  assign srcDt[1] = pipe2b;

  // Frame-level model: a copy snapshots the whole source at its start edge,
  // stays busy for ENTRIES+latency+1 cycles, and on its final cycle the
  // snapshot becomes the displayed table.
  int          busyLeft [2];
  bit          mValid   [2];
  logic [23:0] disp     [2][NENT];
  logic [23:0] snap     [2][NENT];
  logic [23:0] expDt    [2];
  bit          vbPrev;

  function automatic int totalCycles(input int d);
    return NENT + (d + 1) + 1;
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      busyLeft[d] = 0;
      mValid[d]   = 1'b0;
      expDt[d]    = DISABLED;
    end
    vbPrev = 1'b1;
  end

  always @(posedge RCLK) begin
    for (int d = 0; d < 2; d++) begin
      if (RESET) begin
        busyLeft[d] = 0;
        mValid[d]   = 1'b0;
        expDt[d]    = DISABLED;
      end else begin
        expDt[d] = mValid[d] ? disp[d][SPATAD] : DISABLED;
        if (busyLeft[d] > 0) begin
          busyLeft[d] = busyLeft[d] - 1;
          if (busyLeft[d] == 0) begin
            for (int k = 0; k < NENT; k++) disp[d][k] = snap[d][k];
            mValid[d] = 1'b1;
          end
        end else if (VBLANK && !vbPrev && COPY_EN) begin
          busyLeft[d] = totalCycles(d);
          for (int k = 0; k < NENT; k++) snap[d][k] = srcMem[k];
        end
      end
    end
    vbPrev = RESET ? 1'b1 : VBLANK;
  end

  task automatic checkOutput(input string name, input int d,
                             input logic [23:0] got, input logic [23:0] exp);
    vectors++;
    if (got !== exp) begin
      miscomp++;
      $display("[TB] FAIL %s dut%0d: got %h expected %h at %0t", name, d, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output of both instances.
  int busyCnt [2];
  int swapCnt [2];

  always @(negedge RCLK) begin
    if (checking) begin
      for (int d = 0; d < 2; d++) begin
        logic       eBusy, eSwap, eRd;
        logic [6:0] eAd;
        eBusy = busyLeft[d] > 0;
        eSwap = busyLeft[d] == 1;
        eRd   = busyLeft[d] > (d + 2);
        eAd   = eRd ? 7'(totalCycles(d) - busyLeft[d]) : 7'd0;
        checkOutput("BUSY",   d, 24'(busyO[d]), 24'(eBusy));
        checkOutput("SWAP",   d, 24'(swapO[d]), 24'(eSwap));
        checkOutput("SRC_RD", d, 24'(srcRd[d]), 24'(eRd));
        checkOutput("SRC_AD", d, 24'(srcAd[d]), 24'(eAd));
        checkOutput("SPATDT", d, spatDt[d],     expDt[d]);
        busyCnt[d] = busyCnt[d] + int'(busyO[d]);
        swapCnt[d] = swapCnt[d] + int'(swapO[d]);
      end
    end
  end

  task automatic applyStimulus(input int n, input bit randAd);
    repeat (n) begin
      @(negedge RCLK);
      if (randAd) SPATAD = 7'($urandom_range(0, 127));
    end
  endtask

  int busyBase [2];
  int swapBase [2];

  task automatic markCounts();
    for (int d = 0; d < 2; d++) begin
      busyBase[d] = busyCnt[d];
      swapBase[d] = swapCnt[d];
    end
  endtask

  task automatic checkCounts(input string name, input int swaps, input bit expectCopy);
    for (int d = 0; d < 2; d++) begin
      checkOutput({name, " busy cycles"}, d, 24'(busyCnt[d] - busyBase[d]),
                  expectCopy ? 24'(totalCycles(d)) : 24'd0);
      checkOutput({name, " swaps"}, d, 24'(swapCnt[d] - swapBase[d]), 24'(swaps));
    end
  endtask

  // Reads one renderer address and pins both the DUT and the model to a
  // hand-computed word.
  task automatic checkWord(input string name, input int d, input logic [6:0] ad,
                           input logic [23:0] lit);
    @(negedge RCLK);
    SPATAD = ad;
    applyStimulus(1, 1'b0);
    checkOutput({name, " dut"},   d, spatDt[d], lit);
    checkOutput({name, " model"}, d, expDt[d],  lit);
  endtask

  initial begin
    busyCnt = '{0, 0};
    swapCnt = '{0, 0};
    RESET   = 1'b1;
    VBLANK  = 1'b1;
    COPY_EN = 1'b1;
    SPATAD  = 7'd0;
    for (int k = 0; k < NENT; k++) srcMem[k] = 24'h0;

    @(posedge RCLK);
    checking = 1'b1;
    applyStimulus(4, 1'b1);
    RESET = 1'b0;

    // VBLANK already high at reset release must not start a copy.
    markCounts();
    applyStimulus(10, 1'b1);
    checkCounts("vblank high at release", 0, 1'b0);

    // Sweep every renderer address before any copy.
    for (int i = 0; i < NENT; i++) begin
      SPATAD = 7'(i);
      applyStimulus(1, 1'b0);
      if (i > 0) checkOutput("pre-copy sweep", 0, spatDt[0], DISABLED);
    end

    // First copy with a second VBLANK edge 60 cycles in.
    VBLANK = 1'b0;
    applyStimulus(5, 1'b1);
    for (int k = 0; k < NENT; k++) srcMem[k] = {8'h00, 8'(k), ~8'(k)};
    markCounts();
    VBLANK = 1'b1;
    applyStimulus(20, 1'b1);
    VBLANK = 1'b0;
    applyStimulus(40, 1'b1);
    VBLANK = 1'b1;
    applyStimulus(80, 1'b1);
    VBLANK = 1'b0;
    applyStimulus(20, 1'b1);
    checkCounts("first copy", 1, 1'b1);
    checkWord("entry 5", 0, 7'd5, 24'h0005FA);
    checkWord("entry 127 lat2", 1, 7'd127, 24'h007F80);

    // New source, COPY_EN=0: the displayed table must not change.
    for (int k = 0; k < NENT; k++) srcMem[k] = {8'h02, 8'(k), 8'(k)};
    COPY_EN = 1'b0;
    markCounts();
    VBLANK = 1'b1;
    applyStimulus(10, 1'b1);
    VBLANK = 1'b0;
    applyStimulus(140, 1'b1);
    checkCounts("copy disabled", 0, 1'b0);
    checkWord("frozen entry 5", 0, 7'd5, 24'h0005FA);

    // COPY_EN and VBLANK both fall mid-copy: the copy still completes.
    COPY_EN = 1'b1;
    markCounts();
    VBLANK = 1'b1;
    applyStimulus(30, 1'b1);
    COPY_EN = 1'b0;
    VBLANK  = 1'b0;
    applyStimulus(130, 1'b1);
    checkCounts("copy not aborted", 1, 1'b1);
    checkWord("new entry 5", 0, 7'd5, 24'h020505);
    checkWord("new entry 5 lat2", 1, 7'd5, 24'h020505);
    COPY_EN = 1'b1;

    // Reset 40 cycles into a copy abandons it without a flip.
    for (int k = 0; k < NENT; k++) srcMem[k] = 24'($urandom);
    markCounts();
    VBLANK = 1'b1;
    applyStimulus(40, 1'b1);
    RESET = 1'b1;
    applyStimulus(1, 1'b1);
    checkOutput("BUSY after reset", 0, 24'(busyO[0]), 24'd0);
    checkOutput("SPATDT after reset", 0, spatDt[0], DISABLED);
    RESET = 1'b0;
    applyStimulus(20, 1'b1);
    VBLANK = 1'b0;
    applyStimulus(140, 1'b1);
    for (int d = 0; d < 2; d++)
      checkOutput("swaps after reset", d, 24'(swapCnt[d] - swapBase[d]), 24'd0);

    // Randomized frames: random contents, COPY_EN, VBLANK widths and
    // extra VBLANK pulses while busy.
    for (int f = 0; f < 8; f++) begin
      VBLANK = 1'b0;
      applyStimulus($urandom_range(140, 180), 1'b1);
      for (int k = 0; k < NENT; k++) srcMem[k] = 24'($urandom);
      COPY_EN = ($urandom_range(0, 3) != 0);
      VBLANK  = 1'b1;
      applyStimulus($urandom_range(3, 30), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        VBLANK = 1'b0;
        applyStimulus($urandom_range(2, 20), 1'b1);
        VBLANK = 1'b1;
        applyStimulus($urandom_range(2, 20), 1'b1);
      end
    end
    VBLANK = 1'b0;
    applyStimulus(150, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
